mem_channel_arbiter: RTL and testbench
======================================

# mem_channel_arbiter

Shares one external memory channel (one read port, one write port) among `NUM_CONSUMERS` load/store requesters from the compute cores. It sits between the cores' LSUs and the memory interface of the miniGPU top level. It serialises transactions through a small state machine and returns data and ready to the granted requester. At most one memory transaction is outstanding at a time.

## Interface
- `NUM_CONSUMERS`, 8: number of LSU requesters (cores × threads per block).
- `ADDR_BITS`, 8: memory address width.
- `DATA_BITS`, 8: memory data width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `consumer_read_valid`  in  NUM_CONSUMERS  per-requester read request.
- `consumer_read_address`  in  NUM_CONSUMERS*ADDR_BITS  packed addresses; requester i at slice [i*ADDR_BITS +: ADDR_BITS].
- `consumer_read_ready`  out  NUM_CONSUMERS  read data valid / request acknowledged.
- `consumer_read_data`  out  NUM_CONSUMERS*DATA_BITS  packed read data.
- `consumer_write_valid`  in  NUM_CONSUMERS  per-requester write request.
- `consumer_write_address`  in  NUM_CONSUMERS*ADDR_BITS  packed addresses.
- `consumer_write_data`  in  NUM_CONSUMERS*DATA_BITS  packed write data.
- `consumer_write_ready`  out  NUM_CONSUMERS  write acknowledged.
- `mem_read_valid`  out  1  read request to memory.
- `mem_read_address`  out  ADDR_BITS  read address.
- `mem_read_ready`  in  1  memory read data present this cycle.
- `mem_read_data`  in  DATA_BITS  memory read data.
- `mem_write_valid`  out  1  write request to memory.
- `mem_write_address`  out  ADDR_BITS  write address.
- `mem_write_data`  out  DATA_BITS  write data.
- `mem_write_ready`  in  1  memory write accepted this cycle.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- **IDLE:**
  - A requester is pending if its read_valid or write_valid is high.
  - The picker selects one pending index `g` (see Configuration).
  - If read_valid[g] is high, register its address, assert `mem_read_valid`, and go to READ_WAIT. Otherwise do the same with the write address/data, asserting `mem_write_valid`, and go to WRITE_WAIT.
  - Read wins over write for the same requester.
- **READ_WAIT:** hold `mem_read_valid` and address until `mem_read_ready`. In that cycle, latch `mem_read_data` into slice g of `consumer_read_data`, drop `mem_read_valid`, set `consumer_read_ready[g]`, and go to RELAY.
- **WRITE_WAIT:** same pattern; on `mem_write_ready`, drop `mem_write_valid`, set `consumer_write_ready[g]`, and go to RELAY.
- **RELAY:**
  - Hold ready[g] and data until the granted requester deasserts the valid it was served on.
  - Then clear ready[g] and return to IDLE.
  - The priority pointer becomes (g+1) mod NUM_CONSUMERS.
- Data slices of non-granted requesters keep their last value.
- Requests arriving in non-IDLE states wait; no request is dropped.
- Memory ready asserted while the arbiter is not in the matching WAIT state is ignored.

## Timing
- Reset values:
  - all `consumer_*_ready` = 0
  - `consumer_read_data` = 0
  - `mem_*_valid` = 0
  - `mem_*_address` = 0
  - `mem_write_data` = 0
  - `busy` = 0
  - state = IDLE, pointer = 0
- Request sampled at edge N → `mem_*_valid` high after edge N.
- Memory ready at edge M → consumer ready high after edge M.
- Consumer valid low at edge K → ready low and IDLE after edge K.
- Best case, with memory ready in the first WAIT cycle and the consumer dropping valid one cycle after ready: 3 cycles per transaction. Back-to-back grants with no idle gap beyond the IDLE cycle.
- Reset asserted mid-transaction returns all outputs to reset values immediately. The in-flight memory request is abandoned.
- NUM_CONSUMERS = 1: the pointer is constant 0.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: the picker searches from the rotating pointer (fair round-robin).
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, where the lowest pending index always wins and the pointer register is not built.

## Structure
- Shared constants package/include `minigpu_mem_defs`: state encodings (2-bit IDLE=0, READ_WAIT=1, WRITE_WAIT=2, RELAY=3) and default widths.
- One sub-module, `rr_priority_picker`:
  - Inputs: pending vector and pointer.
  - Outputs: one-hot grant and binary index, combinational.
  - Reused by the dispatcher.

## Test plan
- **Single read:** req 2 reads addr 0x1A, memory returns 0x5C one cycle after valid. Required: `mem_read_address`=0x1A, `consumer_read_data` slice 2 = 0x5C, ready[2] held until valid[2] drops, then `busy`=0.
- **Single write:** req 5 writes 0x33 to 0x40. Required: `mem_write_address`=0x40, `mem_write_data`=0x33, `consumer_write_ready[5]` pulses until release.
- **Fairness:** all 8 requesters issue reads continuously.
  - Round-robin: grant order 0,1,…,7,0.
  - Fixed priority: requester 0 is re-served each time.
- **Read/write same requester:** req 3 asserts both. Required: the read is served first, then the write in the following transaction.
- **Memory stall:** `mem_read_ready` held low for 10 cycles. Required: `mem_read_valid` and address stable for all 10 cycles, no other grant.
- **Reset mid-WRITE_WAIT:** required outputs all 0 in the same cycle; after release, a new request from req 7 is served normally.

Source files
------------

// File: rtl/minigpu_mem_defs.sv
// Shared memory-channel definitions: arbiter state encoding and default widths.
package minigpu_mem_defs;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } arb_state_t;

    localparam int unsigned DEF_NUM_CONSUMERS = 8;
    localparam int unsigned DEF_ADDR_BITS     = 8;
    localparam int unsigned DEF_DATA_BITS     = 8;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational picker: first pending index found when searching upward from the pointer.
module rr_priority_picker
    import minigpu_mem_defs::*;
#(
    parameter  int unsigned WIDTH = DEF_NUM_CONSUMERS,
    localparam int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] pending,
    input  logic [IDX_W-1:0] pointer,
    output logic [WIDTH-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned off = 0; off < WIDTH; off++) begin
            cand     = (32'(pointer) + off) % WIDTH;
            cand_idx = IDX_W'(cand);
            if (!found && pending[cand_idx]) begin
                found           = 1'b1;
                index           = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_channel_arbiter.sv
// Serialises LSU read/write requests onto one memory channel, one transaction at a time.
// Define MEM_ARB_ROUND_ROBIN_EN for rotating-pointer fairness; default is fixed priority.
module mem_channel_arbiter
    import minigpu_mem_defs::*;
#(
    parameter int unsigned NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int unsigned ADDR_BITS     = DEF_ADDR_BITS,
    parameter int unsigned DATA_BITS     = DEF_DATA_BITS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready,
    output logic                           busy
);

    localparam int unsigned IDX_W = idx_width(NUM_CONSUMERS);

    arb_state_t       state, nxt_state;
    logic [IDX_W-1:0] grant_idx, nxt_grant_idx;
    logic             served_read, nxt_served_read;
    logic [IDX_W-1:0] rr_ptr;

    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CONSUMERS-1:0] pick_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic                     pick_found;
    logic                     held_valid;

    logic [NUM_CONSUMERS-1:0]           nxt_read_ready;
    logic [NUM_CONSUMERS-1:0]           nxt_write_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] nxt_read_data;
    logic                               nxt_mem_read_valid;
    logic [ADDR_BITS-1:0]               nxt_mem_read_address;
    logic                               nxt_mem_write_valid;
    logic [ADDR_BITS-1:0]               nxt_mem_write_address;
    logic [DATA_BITS-1:0]               nxt_mem_write_data;

    assign pending = consumer_read_valid | consumer_write_valid;
    assign busy    = (state != IDLE);

    rr_priority_picker #(
        .WIDTH (NUM_CONSUMERS)
    ) u_picker (
        .pending (pending),
        .pointer (rr_ptr),
        .grant   (pick_grant),
        .index   (pick_idx),
        .found   (pick_found)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] nxt_ptr;

    // Wraps explicitly so non-power-of-two requester counts stay in range.
    assign nxt_ptr = (grant_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == RELAY && nxt_state == IDLE) begin
            rr_ptr <= nxt_ptr;
        end
    end
`else
    assign rr_ptr = '0;
`endif

    assign held_valid = served_read ? consumer_read_valid[grant_idx]
                                    : consumer_write_valid[grant_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            grant_idx            <= '0;
            served_read          <= 1'b0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            state                <= nxt_state;
            grant_idx            <= nxt_grant_idx;
            served_read          <= nxt_served_read;
            consumer_read_ready  <= nxt_read_ready;
            consumer_write_ready <= nxt_write_ready;
            consumer_read_data   <= nxt_read_data;
            mem_read_valid       <= nxt_mem_read_valid;
            mem_read_address     <= nxt_mem_read_address;
            mem_write_valid      <= nxt_mem_write_valid;
            mem_write_address    <= nxt_mem_write_address;
            mem_write_data       <= nxt_mem_write_data;
        end
    end

    always_comb begin
        nxt_state             = state;
        nxt_grant_idx         = grant_idx;
        nxt_served_read       = served_read;
        nxt_read_ready        = consumer_read_ready;
        nxt_write_ready       = consumer_write_ready;
        nxt_read_data         = consumer_read_data;
        nxt_mem_read_valid    = mem_read_valid;
        nxt_mem_read_address  = mem_read_address;
        nxt_mem_write_valid   = mem_write_valid;
        nxt_mem_write_address = mem_write_address;
        nxt_mem_write_data    = mem_write_data;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    nxt_grant_idx = pick_idx;
                    // Read wins when the chosen requester asks for both.
                    if (|(pick_grant & consumer_read_valid)) begin
                        nxt_served_read      = 1'b1;
                        nxt_mem_read_valid   = 1'b1;
                        nxt_mem_read_address = consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                        nxt_state            = READ_WAIT;
                    end else begin
                        nxt_served_read       = 1'b0;
                        nxt_mem_write_valid   = 1'b1;
                        nxt_mem_write_address = consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
                        nxt_mem_write_data    = consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
                        nxt_state             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    nxt_mem_read_valid = 1'b0;
                    nxt_read_data[grant_idx*DATA_BITS +: DATA_BITS] = mem_read_data;
                    nxt_read_ready[grant_idx] = 1'b1;
                    nxt_state          = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    nxt_mem_write_valid        = 1'b0;
                    nxt_write_ready[grant_idx] = 1'b1;
                    nxt_state                  = RELAY;
                end
            end
            RELAY: begin
                if (!held_valid) begin
                    nxt_read_ready  = '0;
                    nxt_write_ready = '0;
                    nxt_state       = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Scoreboard bench for mem_channel_arbiter; follows MEM_ARB_ROUND_ROBIN_EN for expected grant order.
module tb_mem_channel_arbiter;

    localparam int N  = 8;
    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct {
        bit          is_read;
        int          idx;
        logic [7:0]  addr;
        logic [7:0]  data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    rd_valid;
    logic [N*AW-1:0] rd_addr;
    logic [N-1:0]    rd_ready;
    logic [N*DW-1:0] rd_data;
    logic [N-1:0]    wr_valid;
    logic [N*AW-1:0] wr_addr;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    wr_ready;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;
    logic            mem_write_valid;
    logic [AW-1:0]   mem_write_address;
    logic [DW-1:0]   mem_write_data;
    logic            mem_write_ready;
    logic            busy;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_channel_arbiter #(
        .NUM_CONSUMERS (N),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (rd_valid),
        .consumer_read_address  (rd_addr),
        .consumer_read_ready    (rd_ready),
        .consumer_read_data     (rd_data),
        .consumer_write_valid   (wr_valid),
        .consumer_write_address (wr_addr),
        .consumer_write_data    (wr_data),
        .consumer_write_ready   (wr_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready),
        .busy                   (busy)
    );

    function automatic logic [106:0] all_outs();
        return {rd_ready, wr_ready, rd_data, mem_read_valid, mem_write_valid,
                mem_read_address, mem_write_address, mem_write_data, busy};
    endfunction

    task automatic wait_rd_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_read_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_wr_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_write_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
        mem_read_ready = 1'b0; mem_read_data = '0; mem_write_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL post_reset_idle got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_fairness();
        exp_t e;
        bit   ok;
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = 8'(17 * i);
        for (int k = 0; k < 9; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_q.push_back('{1'b1, k % N, 8'(17 * (k % N)), 8'(8'hC0 + k)});
`else
            exp_q.push_back('{1'b1, 0, 8'h00, 8'(8'hC0 + k)});
`endif
        end
        rd_valid = '1;
        for (int k = 0; k < 9; k++) begin
            wait_rd_valid(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL fair_timeout got=0 exp=1");
            end
            e = exp_q.pop_front();
            checks++;
            if (mem_read_address !== e.addr) begin
                errors++; $display("FAIL fair_grant_addr k=%0d got=%h exp=%h", k, mem_read_address, e.addr);
            end
            mem_read_data = e.data; mem_read_ready = 1'b1;
            @(negedge clk);
            mem_read_ready = 1'b0; mem_read_data = 8'hFF;
            checks++;
            if (rd_ready !== 8'(1 << e.idx) || rd_data[e.idx*DW +: DW] !== e.data) begin
                errors++; $display("FAIL fair_ready k=%0d got=%h/%h exp=%h/%h",
                                   k, rd_ready, rd_data[e.idx*DW +: DW], 8'(1 << e.idx), e.data);
            end
            rd_valid[e.idx] = 1'b0;
            @(negedge clk);
            rd_valid[e.idx] = 1'b1;
        end
        rd_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        exp_t e;
        exp_q.push_back('{1'b1, 2, 8'h1A, 8'h5C});
        e = exp_q[0];
        rd_valid[e.idx] = 1'b1; rd_addr[e.idx*AW +: AW] = e.addr;
        @(negedge clk);
        checks++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== e.addr || busy !== 1'b1) begin
            errors++; $display("FAIL rd_issue got=%b/%h/%b exp=1/%h/1", mem_read_valid, mem_read_address, busy, e.addr);
        end
        mem_read_data = e.data; mem_read_ready = 1'b1;
        @(negedge clk);
        mem_read_ready = 1'b0; mem_read_data = 8'hFF;
        e = exp_q.pop_front();
        checks++;
        if (rd_ready !== 8'(1 << e.idx) || rd_data[e.idx*DW +: DW] !== e.data || mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL rd_return got=%h/%h/%b exp=%h/%h/0",
                               rd_ready, rd_data[e.idx*DW +: DW], mem_read_valid, 8'(1 << e.idx), e.data);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rd_ready !== 8'(1 << e.idx) || rd_data[e.idx*DW +: DW] !== e.data) begin
                errors++; $display("FAIL rd_hold got=%h/%h exp=%h/%h", rd_ready, rd_data[e.idx*DW +: DW], 8'(1 << e.idx), e.data);
            end
        end
        rd_valid[e.idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ready !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_release got=%h/%b exp=00/0", rd_ready, busy);
        end
    endtask

    task automatic test_single_write();
        exp_t e;
        exp_q.push_back('{1'b0, 5, 8'h40, 8'h33});
        e = exp_q[0];
        wr_valid[e.idx] = 1'b1; wr_addr[e.idx*AW +: AW] = e.addr; wr_data[e.idx*DW +: DW] = e.data;
        @(negedge clk);
        checks++;
        if (mem_write_valid !== 1'b1 || mem_write_address !== e.addr || mem_write_data !== e.data || mem_read_valid !== 1'b0) begin
            errors++; $display("FAIL wr_issue got=%b/%h/%h exp=1/%h/%h", mem_write_valid, mem_write_address, mem_write_data, e.addr, e.data);
        end
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (wr_ready !== 8'(1 << e.idx) || mem_write_valid !== 1'b0 || rd_ready !== '0) begin
            errors++; $display("FAIL wr_ack got=%h/%b exp=%h/0", wr_ready, mem_write_valid, 8'(1 << e.idx));
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 8'(1 << e.idx)) begin
            errors++; $display("FAIL wr_hold got=%h exp=%h", wr_ready, 8'(1 << e.idx));
        end
        wr_valid[e.idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_ready !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL wr_release got=%h/%b exp=00/0", wr_ready, busy);
        end
    endtask

    task automatic test_rw_same();
        exp_t e;
        bit   ok;
        exp_q.push_back('{1'b1, 3, 8'h21, 8'h4D});
        exp_q.push_back('{1'b0, 3, 8'h22, 8'h99});
        rd_valid[3] = 1'b1; rd_addr[3*AW +: AW] = 8'h21;
        wr_valid[3] = 1'b1; wr_addr[3*AW +: AW] = 8'h22; wr_data[3*DW +: DW] = 8'h99;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== e.addr) begin
            errors++; $display("FAIL rw_read_first got=%b/%b/%h exp=1/0/%h", mem_read_valid, mem_write_valid, mem_read_address, e.addr);
        end
        mem_read_data = e.data; mem_read_ready = 1'b1;
        @(negedge clk);
        mem_read_ready = 1'b0;
        checks++;
        if (rd_ready !== 8'(1 << e.idx) || wr_ready !== '0) begin
            errors++; $display("FAIL rw_read_ready got=%h/%h exp=%h/00", rd_ready, wr_ready, 8'(1 << e.idx));
        end
        rd_valid[3] = 1'b0;
        @(negedge clk);
        wait_wr_valid(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || mem_write_address !== e.addr || mem_write_data !== e.data) begin
            errors++; $display("FAIL rw_write_second got=%b/%h/%h exp=1/%h/%h", ok, mem_write_address, mem_write_data, e.addr, e.data);
        end
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        checks++;
        if (wr_ready !== 8'(1 << e.idx) || rd_data[3*DW +: DW] !== 8'h4D) begin
            errors++; $display("FAIL rw_write_ready got=%h/%h exp=%h/4d", wr_ready, rd_data[3*DW +: DW], 8'(1 << e.idx));
        end
        wr_valid[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall();
        exp_t e;
        bit   ok;
        exp_q.push_back('{1'b1, 1, 8'h77, 8'hE7});
        exp_q.push_back('{1'b0, 6, 8'h10, 8'h66});
        rd_valid[1] = 1'b1; rd_addr[1*AW +: AW] = 8'h77;
        @(negedge clk);
        wr_valid[6] = 1'b1; wr_addr[6*AW +: AW] = 8'h10; wr_data[6*DW +: DW] = 8'h66;
        for (int c = 0; c < 10; c++) begin
            // A stray write acknowledge mid-stall must not disturb the read.
            mem_write_ready = (c == 4);
            @(negedge clk);
            checks++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h77 || mem_write_valid !== 1'b0 ||
                rd_ready !== '0 || wr_ready !== '0) begin
                errors++; $display("FAIL stall_hold c=%0d got=%b/%h/%b/%h/%h exp=1/77/0/00/00",
                                   c, mem_read_valid, mem_read_address, mem_write_valid, rd_ready, wr_ready);
            end
        end
        mem_write_ready = 1'b0;
        e = exp_q.pop_front();
        mem_read_data = e.data; mem_read_ready = 1'b1;
        @(negedge clk);
        mem_read_ready = 1'b0;
        checks++;
        if (rd_ready !== 8'(1 << e.idx) || rd_data[e.idx*DW +: DW] !== e.data) begin
            errors++; $display("FAIL stall_return got=%h/%h exp=%h/%h", rd_ready, rd_data[e.idx*DW +: DW], 8'(1 << e.idx), e.data);
        end
        rd_valid[1] = 1'b0;
        @(negedge clk);
        wait_wr_valid(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || mem_write_address !== e.addr || mem_write_data !== e.data) begin
            errors++; $display("FAIL stall_waiter got=%b/%h/%h exp=1/%h/%h", ok, mem_write_address, mem_write_data, e.addr, e.data);
        end
        mem_write_ready = 1'b1;
        @(negedge clk);
        mem_write_ready = 1'b0;
        checks++;
        if (wr_ready !== 8'(1 << e.idx)) begin
            errors++; $display("FAIL stall_waiter_ack got=%h exp=%h", wr_ready, 8'(1 << e.idx));
        end
        wr_valid[6] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        bit   ok;
        wr_valid[5] = 1'b1; wr_addr[5*AW +: AW] = 8'h55; wr_data[5*DW +: DW] = 8'hAA;
        @(negedge clk);
        checks++;
        if (mem_write_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre_write got=%b exp=1", mem_write_valid);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL rst_async_clear got=%h exp=0", all_outs());
        end
        wr_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back('{1'b1, 7, 8'hE0, 8'h3C});
        e = exp_q.pop_front();
        rd_valid[e.idx] = 1'b1; rd_addr[e.idx*AW +: AW] = e.addr;
        @(negedge clk);
        wait_rd_valid(ok);
        checks++;
        if (!ok || mem_read_address !== e.addr || mem_write_valid !== 1'b0) begin
            errors++; $display("FAIL rst_new_req got=%b/%h exp=1/%h", ok, mem_read_address, e.addr);
        end
        mem_read_data = e.data; mem_read_ready = 1'b1;
        @(negedge clk);
        mem_read_ready = 1'b0;
        checks++;
        if (rd_ready !== 8'(1 << e.idx) || rd_data !== {e.data, 56'h0}) begin
            errors++; $display("FAIL rst_new_return got=%h/%h exp=%h/%h", rd_ready, rd_data, 8'(1 << e.idx), {e.data, 56'h0});
        end
        rd_valid[e.idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_ready !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_new_release got=%h/%b exp=00/0", rd_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_single_read();
        test_single_write();
        test_rw_same();
        test_stall();
        test_reset_mid_write();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
